// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite slave-side bus bundle for the SRAM slave.
// Master drives address/control/write data; slave returns ready/response/read data.
interface ahb_lite_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [1:0]            HTRANS;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL,
        output HADDR,
        output HWRITE,
        output HSIZE,
        output HBURST,
        output HTRANS,
        output HREADY,
        output HWDATA,
        input  HRDATA,
        input  HREADYOUT,
        input  HRESP
    );

    modport slave (
        input  HSEL,
        input  HADDR,
        input  HWRITE,
        input  HSIZE,
        input  HBURST,
        input  HTRANS,
        input  HREADY,
        input  HWDATA,
        output HRDATA,
        output HREADYOUT,
        output HRESP
    );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite single-port SRAM slave: address/data pipeline, programmable wait
// states, byte/half/word writes and a two-cycle ERROR response.
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input logic HCLK,
    input logic HRESET,
    ahb_lite_sram_slave_if.slave bus
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int OFS_W = IDX_W + 2;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t accept_state;

    logic [3:0]       wait_cnt;
    logic [3:0]       wait_cnt_nxt;
    logic [OFS_W-1:0] addr_q;
    logic [1:0]       size_q;
    logic             write_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic             can_accept;
    logic             accept;
    logic             in_range;
    logic             size_ok;
    logic             aligned;
    logic             legal;
    logic [3:0]       be;
    logic             mem_we;
    logic [IDX_W-1:0] word_idx;
    logic             unused;

    assign unused = ^{bus.HBURST, bus.HTRANS[0]};

    // Legality is judged on the address-phase inputs, before they are registered
    assign in_range = {1'b0, bus.HADDR} < MEM_BYTES;
    assign size_ok  = bus.HSIZE <= 3'd2;

    always_comb begin
        aligned = 1'b1;
        case (bus.HSIZE)
            3'd1:    aligned = ~bus.HADDR[0];
            3'd2:    aligned = bus.HADDR[1:0] == 2'b00;
            default: aligned = 1'b1;
        endcase
    end

    assign legal = in_range & size_ok & aligned;

    always_comb begin
        accept_state = ST_ERR1;
        if (legal) begin
            accept_state = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        can_accept    = 1'b0;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                can_accept = 1'b1;
            end
            ST_WAIT: begin
                bus.HREADYOUT = 1'b0;
                if (wait_cnt <= 4'd1) begin
                    state_nxt    = ST_DATA;
                    wait_cnt_nxt = 4'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            ST_DATA: begin
                can_accept = 1'b1;
                if (bus.HREADY) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
                state_nxt     = ST_ERR2;
            end
            ST_ERR2: begin
                bus.HRESP  = 1'b1;
                can_accept = 1'b1;
                if (bus.HREADY) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        accept = can_accept & bus.HSEL & bus.HREADY & bus.HTRANS[1];
        if (accept) begin
            state_nxt    = accept_state;
            wait_cnt_nxt = legal ? WAIT_INIT : 4'd0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            size_q   <= 2'd0;
            write_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                addr_q  <= bus.HADDR[OFS_W-1:0];
                size_q  <= bus.HSIZE[1:0];
                write_q <= bus.HWRITE;
            end
        end
    end

    assign word_idx = addr_q[OFS_W-1:2];

    always_comb begin
        be = 4'b1111;
        unique case (size_q)
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Commit on the edge that ends DATA; a reset at that edge drops the write
    assign mem_we = (state == ST_DATA) & write_q & bus.HREADY & ~HRESET;

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign bus.HRDATA = (state == ST_DATA && !write_q) ? mem[word_idx] : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for the AHB-Lite SRAM slave: a zero-wait and a two-wait
// instance share one master; a scoreboard queue feeds a negedge bus monitor.
module tb_ahb_lite_sram_slave;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ahb_lite_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    ahb_lite_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        use2;

    logic        ready;
    logic        resp;
    logic [31:0] rdata;

    assign bus0.HSEL   = hsel & ~use2;
    assign bus2.HSEL   = hsel & use2;
    assign bus0.HADDR  = haddr;
    assign bus2.HADDR  = haddr;
    assign bus0.HWRITE = hwrite;
    assign bus2.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;
    assign bus2.HSIZE  = hsize;
    assign bus0.HBURST = hburst;
    assign bus2.HBURST = hburst;
    assign bus0.HTRANS = htrans;
    assign bus2.HTRANS = htrans;
    assign bus0.HWDATA = hwdata;
    assign bus2.HWDATA = hwdata;

    assign ready = use2 ? bus2.HREADYOUT : bus0.HREADYOUT;
    assign resp  = use2 ? bus2.HRESP : bus0.HRESP;
    assign rdata = use2 ? bus2.HRDATA : bus0.HRDATA;

    assign bus0.HREADY = ready;
    assign bus2.HREADY = ready;

    ahb_lite_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)
    ) u_dut0 (
        .HCLK(clk),
        .HRESET(rst),
        .bus(bus0)
    );

    ahb_lite_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)
    ) u_dut2 (
        .HCLK(clk),
        .HRESET(rst),
        .bus(bus2)
    );

    typedef struct {
        string       name;
        logic        resp;
        int          waits;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   asserts = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Bus monitor: tracks data phases from the bus itself, pops on completion
    initial begin : monitor
        bit   dph;
        int   wc;
        exp_t e;
        dph = 1'b0;
        wc  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dph = 1'b0;
                wc  = 0;
            end else if (dph) begin
                if (!ready) begin
                    if (sb.size() > 0) begin
                        chk({sb[0].name, " wait resp"}, 32'(resp), 32'(sb[0].resp));
                    end
                    wc++;
                    if (wc > 20) begin
                        chk("data phase bound", 32'(wc), 32'd0);
                        dph = 1'b0;
                        wc  = 0;
                        if (sb.size() > 0) begin
                            void'(sb.pop_front());
                        end
                    end
                end else begin
                    if (sb.size() == 0) begin
                        chk("unexpected completion", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, " resp"}, 32'(resp), 32'(e.resp));
                        chk({e.name, " waits"}, 32'(wc), 32'(e.waits));
                        chk({e.name, " rdata"}, rdata, e.rdata);
                    end
                    wc = 0;
                end
            end else begin
                chk("idle ready/resp", 32'({ready, resp}), 32'b10);
                chk("idle rdata", rdata, 32'd0);
            end
            if (!rst && ready) begin
                dph = hsel & htrans[1];
            end
        end
    end

    task automatic accept_edge();
        bit r;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            r = ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 50);
        chk("address phase accepted", 32'(r), 32'd1);
    endtask

    task automatic xfer(input string nm, input bit wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd,
                        input bit err, input logic [31:0] rd);
        exp_t e;
        hsel   = 1'b1;
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
        htrans = 2'b10;
        e.name  = nm;
        e.resp  = err;
        e.waits = err ? 1 : (use2 ? 2 : 0);
        e.rdata = (!wr && !err) ? rd : 32'd0;
        sb.push_back(e);
        accept_edge();
        hwdata = wd;
    endtask

    task automatic idle(input int n, input logic [1:0] tr);
        hsel   = 1'b1;
        htrans = tr;
        repeat (n) accept_edge();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "simulation timed out");
    end

    initial begin : stim
        hsel   = 1'b0;
        haddr  = 32'd0;
        hwrite = 1'b0;
        hsize  = 3'd0;
        hburst = 3'd0;
        htrans = 2'b00;
        hwdata = 32'd0;
        use2   = 1'b0;

        #1 rst = 1'b1;
        #1;
        chk("reset ready", 32'(bus0.HREADYOUT), 32'd1);
        chk("reset resp", 32'(bus0.HRESP), 32'd0);
        chk("reset rdata", bus0.HRDATA, 32'd0);
        chk("reset ready ws2", 32'(bus2.HREADYOUT), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        xfer("wr 0x10", 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 0);
        xfer("rd 0x10", 0, 32'h10, 3'd2, 32'h0, 0, 32'hDEADBEEF);

        xfer("wr 0x20", 1, 32'h20, 3'd2, 32'h11223344, 0, 0);
        xfer("wb 0x23", 1, 32'h23, 3'd0, 32'hAA000000, 0, 0);
        xfer("wh 0x20", 1, 32'h20, 3'd1, 32'h0000BEEF, 0, 0);
        xfer("rd 0x20", 0, 32'h20, 3'd2, 32'h0, 0, 32'hAA22BEEF);

        xfer("wr 0x30", 1, 32'h30, 3'd2, 32'h00000000, 0, 0);
        xfer("wh 0x32", 1, 32'h32, 3'd1, 32'h12340000, 0, 0);
        xfer("wb 0x30", 1, 32'h30, 3'd0, 32'h000000CD, 0, 0);
        xfer("rd 0x30", 0, 32'h30, 3'd2, 32'h0, 0, 32'h123400CD);

        xfer("wr 0x3FC", 1, 32'h3FC, 3'd2, 32'h0BADF00D, 0, 0);
        xfer("rd 0x3FC", 0, 32'h3FC, 3'd2, 32'h0, 0, 32'h0BADF00D);

        xfer("err rd 0x400", 0, 32'h400, 3'd2, 32'h0, 1, 0);
        xfer("err rd 0x02", 0, 32'h02, 3'd2, 32'h0, 1, 0);
        xfer("err wr 0x12", 1, 32'h12, 3'd2, 32'hFFFFFFFF, 1, 0);
        xfer("err wr size3", 1, 32'h10, 3'd3, 32'hFFFFFFFF, 1, 0);
        xfer("err wh 0x11", 1, 32'h11, 3'd1, 32'hFFFFFFFF, 1, 0);
        xfer("err wb 0x400", 1, 32'h400, 3'd0, 32'hFFFFFFFF, 1, 0);
        xfer("rd 0x10 kept", 0, 32'h10, 3'd2, 32'h0, 0, 32'hDEADBEEF);

        hburst = 3'b001;
        xfer("wr 0x40", 1, 32'h40, 3'd2, 32'h5A5A5A5A, 0, 0);
        xfer("rd 0x40", 0, 32'h40, 3'd2, 32'h0, 0, 32'h5A5A5A5A);
        idle(2, 2'b00);
        idle(2, 2'b01);
        xfer("rd 0x40 again", 0, 32'h40, 3'd2, 32'h0, 0, 32'h5A5A5A5A);
        hburst = 3'b000;
        idle(2, 2'b00);

        use2 = 1'b1;
        xfer("ws2 wr 0x10", 1, 32'h10, 3'd2, 32'hCAFEF00D, 0, 0);
        xfer("ws2 rd 0x10", 0, 32'h10, 3'd2, 32'h0, 0, 32'hCAFEF00D);
        xfer("ws2 err 0x400", 0, 32'h400, 3'd2, 32'h0, 1, 0);
        idle(2, 2'b00);

        hsel   = 1'b1;
        haddr  = 32'h10;
        hwrite = 1'b1;
        hsize  = 3'd2;
        htrans = 2'b10;
        accept_edge();
        hwdata = 32'h12345678;
        hsel   = 1'b0;
        htrans = 2'b00;
        @(negedge clk);
        chk("mid-wait ready", 32'(ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async reset ready", 32'(ready), 32'd1);
        chk("async reset resp", 32'(resp), 32'd0);
        chk("async reset rdata", rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        xfer("ws2 rd after rst", 0, 32'h10, 3'd2, 32'h0, 0, 32'hCAFEF00D);
        idle(2, 2'b00);
        use2 = 1'b0;
        xfer("rd 0x40 after rst", 0, 32'h40, 3'd2, 32'h0, 0, 32'h5A5A5A5A);
        xfer("rd 0x20 after rst", 0, 32'h20, 3'd2, 32'h0, 0, 32'hAA22BEEF);
        idle(3, 2'b00);
        hsel = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
